// File: rtl/uart_byte_fifo_if.sv
// Byte FIFO bus: upstream decoder strobe, host read side, status and trigger controls.
// The master modport drives the FIFO inputs; the slave modport is the FIFO itself.
interface uart_byte_fifo_if #(
  parameter int ADDR_W = 3
);
  logic [7:0]      in_data;
  logic            in_valid;
  logic            clear;
  logic            rd_en;
  logic [7:0]      rd_data;
  logic            rd_valid;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            arm;
  logic [7:0]      trig_byte;
  logic            triggered;

  modport master (
    output in_data, in_valid, clear, rd_en, arm, trig_byte,
    input  rd_data, rd_valid, empty, full, count, overflow, triggered
  );

  modport slave (
    input  in_data, in_valid, clear, rd_en, arm, trig_byte,
    output rd_data, rd_valid, empty, full, count, overflow, triggered
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between a UART decoder and host readout, with registered read port and sticky overflow.
// Optional macro TRIGGER_MATCH_EN gates capture behind an arm/match trigger FSM.
module uart_byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic            clk,
  input logic            rst,
  uart_byte_fifo_if.slave bus
);

  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_STEP = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;
  logic              r_rd_valid;
  logic [7:0]        r_rd_data;

  logic              w_cap_en;
  logic              w_wr_req;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_drop;
  logic [ADDR_W:0]   w_count_nxt;

  // Accept/drop decisions; clear discards both sides for this cycle.
  always_comb begin
    w_wr_req = bus.in_valid && w_cap_en;
    w_rd_acc = 1'b0;
    w_wr_acc = 1'b0;
    w_drop   = 1'b0;
    if (bus.clear) begin
      w_rd_acc = 1'b0;
      w_wr_acc = 1'b0;
      w_drop   = 1'b0;
    end else begin
      w_rd_acc = bus.rd_en && !r_empty;
      // A same-cycle read frees the slot, so a full FIFO still accepts the write.
      w_wr_acc = w_wr_req && (!r_full || w_rd_acc);
      w_drop   = w_wr_req && r_full && !w_rd_acc;
    end
  end

  // Next occupancy from the accepted read/write pair.
  always_comb begin
    w_count_nxt = r_count;
    if (bus.clear) begin
      w_count_nxt = CNT_ZERO;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + CNT_STEP;
        2'b01:   w_count_nxt = r_count - CNT_STEP;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Storage array; contents are only observable through the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy flags, overflow and the registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= PTR_ZERO;
      r_rd_ptr   <= PTR_ZERO;
      r_count    <= CNT_ZERO;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == CNT_ZERO);
      r_full     <= (w_count_nxt == CNT_MAX);
      r_rd_valid <= w_rd_acc;
      if (bus.clear) begin
        r_wr_ptr   <= PTR_ZERO;
        r_rd_ptr   <= PTR_ZERO;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + PTR_STEP;
        end
        if (w_rd_acc) begin
          r_rd_ptr <= r_rd_ptr + PTR_STEP;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef TRIGGER_MATCH_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10
  } trig_state_t;

  trig_state_t r_state;
  trig_state_t w_state_nxt;
  logic        w_match;

  // Trigger state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Trigger next state and capture enable; the matching byte itself is captured.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_en    = 1'b0;
    w_match     = bus.in_valid && (bus.in_data == bus.trig_byte);
    case (r_state)
      ST_IDLE:    w_cap_en = 1'b0;
      ST_ARMED:   w_cap_en = w_match;
      ST_CAPTURE: w_cap_en = 1'b1;
      default:    w_cap_en = 1'b0;
    endcase
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.arm) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (w_match) begin
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end
        ST_CAPTURE: w_state_nxt = ST_CAPTURE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.triggered = (r_state == ST_CAPTURE);
`else
  logic w_unused_trig;

  assign w_cap_en      = 1'b1;
  assign bus.triggered = 1'b1;
  assign w_unused_trig = ^{bus.arm, bus.trig_byte};
`endif

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.empty    = r_empty;
  assign bus.full     = r_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_uart_byte_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam logic [7:0] TRIG = 8'hA5;

  logic clk = 1'b0;
  logic rst;

  uart_byte_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_rv;
  logic [7:0] m_rd;
  int         m_ts;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit exp_trig;
`ifdef TRIGGER_MATCH_EN
    exp_trig = (m_ts == 2);
`else
    exp_trig = 1'b1;
`endif
    check_val("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    check_val("rd_data", 32'(bus.rd_data), 32'(m_rd));
    check_val("count", 32'(bus.count), 32'(m_q.size()));
    check_val("empty", 32'(bus.empty), 32'(m_q.size() == 0));
    check_val("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
    check_val("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_val("triggered", 32'(bus.triggered), 32'(exp_trig));
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit r, input bit c, input bit a);
    int sz;
    bit cap;
    bit racc;
    sz = m_q.size();
`ifdef TRIGGER_MATCH_EN
    cap = (m_ts == 2) || (m_ts == 1 && v && d == TRIG);
`else
    cap = 1'b1;
`endif
    if (c) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_rv  = 1'b0;
      m_ts  = 0;
    end else begin
      racc = r && (sz > 0);
      m_rv = racc;
      if (racc) m_rd = m_q.pop_front();
      if (v && cap) begin
        if (sz < DEPTH || racc) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
      if (m_ts == 0 && a) m_ts = 1;
      else if (m_ts == 1 && v && d == TRIG) m_ts = 2;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit c, input bit a);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_en    = r;
    bus.clear    = c;
    bus.arm      = a;
    model_step(v, d, r, c, a);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.clear    = 1'b0;
    bus.arm      = 1'b0;
    rst = 1'b1;
    m_q.delete();
    m_ovf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = 8'h00;
    m_ts  = 0;
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // With the trigger build, get into CAPTURE (capturing TRIG) and drain it again.
  task automatic capture_on();
`ifdef TRIGGER_MATCH_EN
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, TRIG, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.rd_en     = 1'b0;
    bus.arm       = 1'b0;
    bus.trig_byte = TRIG;
    rst = 1'b0;
    do_reset();
    capture_on();

    // Basic ordering and count down to empty.
    wr(8'h11); wr(8'h22); wr(8'h33);
    rd(); rd(); rd(); idle();

    // Fill past depth: ninth byte dropped, sticky overflow.
    for (int i = 0; i < DEPTH + 1; i++) wr(8'(8'h40 + i));
    idle();
    for (int i = 0; i < DEPTH + 1; i++) rd();
    idle();
    do_clear();
    capture_on();

    // Full with simultaneous write and read.
    for (int i = 0; i < DEPTH; i++) wr(8'(8'h60 + i));
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) rd();
    idle();

    // Pointer wrap.
    for (int i = 0; i < 5; i++) wr(8'(8'h80 + i));
    for (int i = 0; i < 5; i++) rd();
    for (int i = 0; i < 6; i++) wr(8'(8'hC0 + i));
    for (int i = 0; i < 6; i++) rd();
    idle();

    // Read on empty with a same-cycle write: no fall-through.
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    rd(); idle();

    // Clear beats same-cycle read and write.
    for (int i = 0; i < 4; i++) wr(8'(8'h20 + i));
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    idle();
    capture_on();

    // Reset mid-operation discards stored bytes.
    wr(8'h01); wr(8'h02); wr(8'h03);
    do_reset();
    capture_on();
    wr(8'h0A); wr(8'h0B);
    rd(); rd(); idle();

`ifdef TRIGGER_MATCH_EN
    // Arm then 3C, A5, 7E: only A5 and 7E land.
    do_clear();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    wr(8'h3C); wr(TRIG); wr(8'h7E);
    rd(); rd(); rd(); idle();
`endif

    // Random traffic with alternating fill- and drain-biased phases.
    for (int i = 0; i < 3000; i++) begin
      bit v, r, c, a;
      logic [7:0] d;
      bit fill_phase;
      fill_phase = ((i / 64) % 2) == 0;
      v = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 127) == 0);
      a = ($urandom_range(0, 15) == 0);
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = TRIG;
      step(v, d, r, c, a);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_fifo.md
UART_BYTE_FIFO -- requirements
Module: uart_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of byte entries; SHALL be a power of two, 2..16.
REQ-002 Parameter ADDR_W, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 The clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_data  input  8  decoded byte from upstream UART decoder.
REQ-007 in_valid  input  1  one-cycle strobe qualifying in_data.
REQ-008 clear  input  1  synchronous flush.
REQ-009 rd_en  input  1  read request from host/readout logic.
REQ-010 rd_data  output  8  registered read byte.
REQ-011 rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-012 empty  output  1  high when count==0.
REQ-013 full  output  1  high when count==DEPTH.
REQ-014 count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 overflow  output  1  sticky, a byte was dropped.
REQ-016 arm  input  1  trigger arm pulse (used only with TRIGGER_MATCH_EN).
REQ-017 trig_byte  input  8  trigger match value (used only with TRIGGER_MATCH_EN).
REQ-018 triggered  output  1  high while capture is enabled.

Function
REQ-019 Write: in_valid && capture-enabled && (!full || read accepted same cycle) SHALL store in_data at write pointer, advance pointer modulo DEPTH.
REQ-020 in_valid && capture-enabled && full && no read accepted SHALL drop the byte and set overflow; memory, pointers, count unchanged.
REQ-021 Read: rd_en && !empty SHALL present the oldest byte on rd_data with rd_valid high the next cycle (1-cycle latency), advance read pointer modulo DEPTH.
REQ-022 rd_en while empty SHALL be ignored; rd_valid stays low; no fall-through of a same-cycle write.
REQ-023 rd_data SHALL hold its last value when rd_valid is low.
REQ-024 Simultaneous accepted read and write SHALL leave count unchanged, including when full.
REQ-025 Otherwise count SHALL increment on accepted write, decrement on accepted read; empty/full derived from registered count, valid same cycle as count.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 without affecting count.
REQ-027 clear SHALL zero pointers and count, clear overflow and rd_valid; clear wins over same-cycle read/write (both discarded); rd_data unchanged.
REQ-028 Without TRIGGER_MATCH_EN capture-enabled SHALL be constant 1 and triggered SHALL be constant 1.

Reset
REQ-029 rst SHALL asynchronously force: pointers 0, count 0, empty 1, full 0, overflow 0, rd_valid 0, rd_data 8'h00, trigger state IDLE.
REQ-030 Memory contents SHALL NOT require reset; only pointer-addressed data is observable.
REQ-031 Reset mid-operation SHALL discard all stored bytes; first post-reset read returns first post-reset write.

Configuration
REQ-032 Macro TRIGGER_MATCH_EN, when defined, SHALL add trigger FSM IDLE -> ARMED -> CAPTURE; capture-enabled only in CAPTURE; triggered=1 only in CAPTURE.
REQ-033 IDLE: arm -> ARMED; in_valid ignored.
REQ-034 ARMED: in_valid && in_data==trig_byte SHALL write that byte and enter CAPTURE same edge; non-matching bytes discarded, no overflow.
REQ-035 CAPTURE: stays until clear or rst; arm ignored.
REQ-036 clear in any state SHALL return FSM to IDLE; clear beats arm in same cycle.
REQ-037 Without the macro arm and trig_byte SHALL be unused, no FSM logic.

Verification
REQ-038 Write 8'h11,22,33 then 3 rd_en -> rd_data 11,22,33 each 1 cycle after rd_en, count 3->0, empty=1.
REQ-039 Write 9 bytes into DEPTH=8 -> full=1 after 8th, 9th dropped, overflow=1, reads return first 8 in order.
REQ-040 Full FIFO, in_valid+rd_en same cycle -> count stays 8, overflow 0, new byte read last.
REQ-041 Write 5, read 5, write 6 (wrap) -> reads return the 6 in order, count 0 after.
REQ-042 clear with in_valid and rd_en asserted, count 4 -> count 0, empty 1, overflow 0, rd_valid 0 next cycle.
REQ-043 With TRIGGER_MATCH_EN, trig_byte=8'hA5, arm, send 3C,A5,7E -> FIFO holds A5,7E; triggered rises on A5 edge.
